seq_alu_exec: RTL and testbench
===============================

Name: seq_alu_exec

Overview:
- Multi-cycle execute unit on the consumer side of the `alu_order` interface. It takes the 4-bit `ALU_*` opcode from the ALU control decoder plus two operands and returns the result.
- Sits in the EX stage and talks valid/ready on both sides.
- Logic, compare, add/sub and pass-through ops finish in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle, which saves the barrel shifter.

Parameters:
- XLEN, 32, operand/result width.
- SHIFT_STEP, 1, bits shifted per SHIFT cycle. Legal values are 1, 2, 4, 8, 16; others are a synthesis-time error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort of any in-flight op.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- alu_order  input  4  opcode, `ALU_*` macros from define.v.
- op_a  input  XLEN  operand 1 (rs1).
- op_b  input  XLEN  operand 2 (rs2 or immediate).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0; used with `ALU_SUB` for BEQ/BNE.
- illegal  output  1  opcode not a defined `ALU_*` code.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - in_ready=0 while rst_n low, 1 from the first edge after release.
  - out_valid=0, result=0, zero=1, illegal=0.
  - Internal shift counter and operands are cleared.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready), and is forced to 0 when flush=1.
- Accept happens when in_valid && in_ready. alu_order, op_a, op_b and shamt=op_b[4:0] are captured in that cycle. Inputs are ignored at all other times.
- Opcode semantics:
  - ADD: a+b, mod 2^XLEN.
  - SUB: a-b, mod 2^XLEN.
  - L: signed a<b, giving {0..,1} or 0.
  - UL: unsigned a<b.
  - XOR, OR, AND: bitwise.
  - LL: logical shift left.
  - LR: logical shift right.
  - CR: arithmetic shift right, sign-filled.
  - D2: result = b.
  - Any other code: result=0, illegal=1, completes in one cycle.
- Non-shift ops, or shift with shamt=0: state goes to DONE on the edge after accept. out_valid=1 one cycle after accept.
- Shift with shamt>0:
  - State goes to SHIFT with the working register = a and remaining = shamt.
  - Each SHIFT cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same amount.
  - When remaining reaches 0, state goes to DONE.
  - out_valid rises ceil(shamt/SHIFT_STEP)+1 cycles after accept.
- DONE:
  - out_valid=1. result, zero and illegal stay stable until out_ready=1.
  - On out_ready with no new accept: state goes to IDLE, out_valid=0 next cycle. result holds its last value.
  - On out_ready with a simultaneous accept: the new op starts with no bubble.
- Backpressure: out_ready=0 holds DONE indefinitely. Outputs must not change.
- flush=1 (priority over everything except reset):
  - State goes to IDLE next edge, out_valid=0, pending result discarded.
  - No accept occurs in the flush cycle.
  - result/zero are not required to be cleared.
- Reset mid-shift: immediate abort to reset values. No partial result is emitted.
- Only op_b[4:0] is used for shifts (RV32I), independent of XLEN.
- zero is computed from the final result register.

Test Plan:
- Reset then ADD a=32'h7FFF_FFFF, b=1 with out_ready=1 -> out_valid one cycle after accept, result=32'h8000_0000, zero=0, illegal=0. Back-to-back SUB a=5, b=5 accepted in the DONE cycle -> next result=0, zero=1.
- L a=32'hFFFF_FFFF, b=1 -> result=1. UL with the same operands -> result=0. D2 b=32'h1234_5000 -> result=32'h1234_5000.
- SHIFT_STEP=1:
  - CR a=32'h8000_0000, b=31 -> result=32'hFFFF_FFFF, out_valid exactly 32 cycles after accept.
  - LL a=1, b=32'h0000_0020 (shamt=0) -> result=1 after 1 cycle.
  - LR a=32'hF000_0000, b=4 -> result=32'h0F00_0000 after 5 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after an XOR a=32'hFF00, b=32'h0FF0 -> result stays 32'hF0F0, out_valid stays 1, in_ready=0 throughout.
- flush asserted on the 3rd SHIFT cycle of LL b=20, with in_valid=1 held -> no out_valid. in_ready=0 in the flush cycle, 1 the next cycle, and the next op is accepted normally.
- Undefined alu_order (code not in define.v) -> result=0, illegal=1 for one transaction. async rst_n pulse mid-SHIFT -> out_valid=0 and in_ready=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/seq_alu_exec.sv
`default_nettype none
// ============================================================================
// seq_alu_exec : EX-stage ALU, single-cycle ops plus iterative shifter
// Rev 1.0
// ============================================================================
module seq_alu_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_order,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] c_alu_add = 4'd0;
  localparam logic [3:0] c_alu_sub = 4'd1;
  localparam logic [3:0] c_alu_ll  = 4'd2;
  localparam logic [3:0] c_alu_l   = 4'd3;
  localparam logic [3:0] c_alu_ul  = 4'd4;
  localparam logic [3:0] c_alu_xor = 4'd5;
  localparam logic [3:0] c_alu_lr  = 4'd6;
  localparam logic [3:0] c_alu_cr  = 4'd7;
  localparam logic [3:0] c_alu_or  = 4'd8;
  localparam logic [3:0] c_alu_and = 4'd9;
  localparam logic [3:0] c_alu_d2  = 4'd10;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  localparam logic [4:0] c_step = 5'(SHIFT_STEP);

  generate
    if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4 &&
        SHIFT_STEP != 8 && SHIFT_STEP != 16) begin : g_bad_step
      $error("seq_alu_exec: SHIFT_STEP must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rem_q, rem_d;
  logic [3:0]      op_q, op_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            live_q;

  logic            accept;
  logic            is_shift;
  logic [4:0]      shamt;
  logic [4:0]      step;
  logic [4:0]      rem_next;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [XLEN-1:0] shifted;

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready  = live_q && !flush &&
                     ((state_q == c_st_idle) || ((state_q == c_st_done) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == c_st_done);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  assign shamt    = op_b[4:0];
  assign is_shift = (alu_order == c_alu_ll) || (alu_order == c_alu_lr) ||
                    (alu_order == c_alu_cr);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_order)
      c_alu_add: alu_res = op_a + op_b;
      c_alu_sub: alu_res = op_a - op_b;
      c_alu_l:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      c_alu_ul:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      c_alu_xor: alu_res = op_a ^ op_b;
      c_alu_or:  alu_res = op_a | op_b;
      c_alu_and: alu_res = op_a & op_b;
      c_alu_d2:  alu_res = op_b;
      c_alu_ll, c_alu_lr, c_alu_cr: alu_res = op_a;  // only reached with shamt == 0
      default:   alu_ill = 1'b1;
    endcase
  end

  assign step     = (rem_q < c_step) ? rem_q : c_step;
  assign rem_next = rem_q - step;

  always_comb begin
    case (op_q)
      c_alu_ll: shifted = work_q << step;
      c_alu_lr: shifted = work_q >> step;
      default:  shifted = $unsigned($signed(work_q) >>> step);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    rem_d     = rem_q;
    op_d      = op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = c_st_idle;
    end else if (accept) begin
      op_d   = alu_order;
      work_d = op_a;
      if (is_shift && (shamt != 5'd0)) begin
        state_d   = c_st_shift;
        rem_d     = shamt;
        illegal_d = 1'b0;
      end else begin
        state_d   = c_st_done;
        rem_d     = 5'd0;
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        illegal_d = alu_ill;
      end
    end else begin
      case (state_q)
        c_st_shift: begin
          work_d = shifted;
          rem_d  = rem_next;
          if (rem_next == 5'd0) begin
            state_d  = c_st_done;
            result_d = shifted;
            zero_d   = (shifted == '0);
          end
        end
        c_st_done: if (out_ready) state_d = c_st_idle;
        default:   state_d = c_st_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_st_idle;
      work_q    <= '0;
      rem_q     <= 5'd0;
      op_q      <= 4'd0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      op_q      <= op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      live_q    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_exec.sv
`default_nettype none
// ============================================================================
// tb_seq_alu_exec : directed vectors, scoreboard against an ALU reference model
// Rev 1.0
// ============================================================================
module tb_seq_alu_exec;

  localparam int XLEN = 32;
  localparam int STEP = 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LL  = 4'd2;
  localparam logic [3:0] OP_L   = 4'd3;
  localparam logic [3:0] OP_UL  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LR  = 4'd6;
  localparam logic [3:0] OP_CR  = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_AND = 4'd9;
  localparam logic [3:0] OP_D2  = 4'd10;
  localparam logic [3:0] OP_BAD = 4'd15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_order = 4'd0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  seq_alu_exec #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_order(alu_order), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what each opcode must produce, straight from the op definitions
  function automatic logic [XLEN-1:0] model_res(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sbv;
    int sh;
    sa = a; sbv = b; sh = int'(b[4:0]);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_L:   return (sa < sbv) ? XLEN'(1) : XLEN'(0);
      OP_UL:  return (a < b) ? XLEN'(1) : XLEN'(0);
      OP_XOR: return a ^ b;
      OP_OR:  return a | b;
      OP_AND: return a & b;
      OP_D2:  return b;
      OP_LL:  return a << sh;
      OP_LR:  return a >> sh;
      OP_CR:  return sa >>> sh;
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [XLEN-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((op == OP_LL || op == OP_LR || op == OP_CR) && sh != 0) return (sh + STEP - 1) / STEP + 1;
    return 1;
  endfunction

  typedef struct {
    logic [XLEN-1:0] res;
    logic            zro;
    logic            ill;
    int              due;
  } exp_t;

  exp_t sb[$];
  bit   head_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      head_seen = 1'b0;
    end else begin
      if (sb.size() == 0) begin
        check("idle_out_valid", out_valid, 0);
      end else if (out_valid) begin
        if (!head_seen) begin
          check("sb_latency_cycle", cyc, sb[0].due);
          head_seen = 1'b1;
        end
        check("sb_result", result, sb[0].res);
        check("sb_zero", zero, sb[0].zro);
        check("sb_illegal", illegal, sb[0].ill);
        if (out_ready && !flush) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end else begin
        check("sb_pending_not_late", (cyc < sb[0].due) ? 1 : 0, 1);
      end
      if (flush) begin
        sb.delete();
        head_seen = 1'b0;
      end else if (in_valid && in_ready) begin
        e.res = model_res(alu_order, op_a, op_b);
        e.zro = (e.res == '0);
        e.ill = (alu_order > OP_D2);
        e.due = cyc + model_lat(alu_order, op_b);
        sb.push_back(e);
      end
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int acc, n;
    @(posedge clk); #1;
    alu_order = op; op_a = a; op_b = b; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    check({name, "_accept"}, in_ready, 1);
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check({name, "_latency"}, cyc - acc, exp_lat);
    check({name, "_result"}, result, exp_res);
    check({name, "_zero"}, zero, (exp_res == '0) ? 1 : 0);
    check({name, "_illegal"}, illegal, exp_ill);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_illegal", illegal, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("rel_in_ready_before_edge", in_ready, 0);
    @(negedge clk); check("rel_in_ready_after_edge", in_ready, 1);

    // ADD then SUB accepted in the ADD's DONE cycle
    @(posedge clk); #1;
    alu_order = OP_ADD; op_a = 32'h7FFF_FFFF; op_b = 32'd1; in_valid = 1'b1;
    @(negedge clk); check("add_accept", in_ready, 1);
    @(posedge clk); #1;
    alu_order = OP_SUB; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_result", result, 32'h8000_0000);
    check("add_zero", zero, 0);
    check("add_illegal", illegal, 0);
    check("sub_b2b_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("sub_valid", out_valid, 1);
    check("sub_result", result, 32'd0);
    check("sub_zero", zero, 1);

    run_op("slt",  OP_L,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    run_op("sltu", OP_UL, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    run_op("pass", OP_D2, 32'h0, 32'h1234_5000, 32'h1234_5000, 1'b0, 1);
    run_op("and",  OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
    run_op("or",   OP_OR,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1);
    run_op("sra",  OP_CR, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 32);
    run_op("sll0", OP_LL, 32'd1, 32'h0000_0020, 32'd1, 1'b0, 1);
    run_op("srl",  OP_LR, 32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, 5);
    run_op("sll",  OP_LL, 32'h0000_0003, 32'd30, 32'hC000_0000, 1'b0, 31);
    run_op("bad",  OP_BAD, 32'h1234, 32'h5678, 32'd0, 1'b1, 1);
    run_op("post_bad", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    // Backpressure on an XOR result
    @(posedge clk); #1;
    out_ready = 1'b0;
    alu_order = OP_XOR; op_a = 32'h0000_FF00; op_b = 32'h0000_0FF0; in_valid = 1'b1;
    @(negedge clk); check("xor_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 32'h0000_F0F0);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 1);
    check("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    check("bp_after_valid", out_valid, 0);
    check("bp_result_holds", result, 32'h0000_F0F0);

    // Flush on the third SHIFT cycle with in_valid held high
    @(posedge clk); #1;
    alu_order = OP_LL; op_a = 32'd3; op_b = 32'd20; in_valid = 1'b1;
    @(negedge clk); check("flush_op_accept", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("flush_out_valid", out_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    alu_order = OP_ADD; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk); check("post_flush_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_valid", out_valid, 1);
    check("post_flush_result", result, 32'd7);
    repeat (25) @(negedge clk);

    // Asynchronous reset in the middle of a shift
    @(posedge clk); #1;
    alu_order = OP_CR; op_a = 32'h8000_0000; op_b = 32'd31; in_valid = 1'b1;
    @(negedge clk); check("rst_shift_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", zero, 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("midrst_rel_before_edge", in_ready, 0);
    @(negedge clk); check("midrst_rel_after_edge", in_ready, 1);
    run_op("after_rst", OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1);

    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
